// File: rtl/nib_mem_responder.sv
// -----------------------------------------------------------------------------
// nib_mem_responder
//
// Stand-in memory for the core NIB bus. It serves two ports from one word
// array:
//   * an instruction-fetch port that returns NUM_FETCH words per request.
//     Lane k reads the word at pc_addr_i + k*FETCH_STRIDE. The fetch port has
//     a fixed one-cycle latency and is never stalled.
//   * a data port that accepts one request at a time, supports byte-enable
//     writes, and returns read data after RD_LATENCY cycles.
// The block can also inject periodic hold (stall) requests, flags accesses
// beyond DEPTH words and counts accepted writes.
//
// Ports
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset (memory contents survive it)
//   pc_req_i     fetch request
//   pc_addr_i    fetch byte address of lane 0
//   pc_data_o    fetched words; lane k is in [k*DATA_W +: DATA_W]
//   pc_valid_o   pc_data_o valid, pc_req_i delayed by one cycle
//   ex_req_i     data request, held high by the requester until granted
//   ex_we_i      1 = write, 0 = read
//   ex_addr_i    data byte address
//   ex_wdata_i   write data
//   ex_be_i      write byte enables
//   ex_rdata_o   read data; holds its last value while ex_rvalid_o is low
//   ex_rvalid_o  read data valid, single-cycle pulse
//   ex_gnt_o     request accepted, single-cycle pulse one cycle after accept
//   hold_req_o   stall request to the core
//   err_o        out-of-range data access, pulses together with ex_gnt_o
//   wr_cnt_o     number of accepted in-range writes, wraps at 2^32
// -----------------------------------------------------------------------------
module nib_mem_responder #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DEPTH        = 4096,
  parameter int unsigned NUM_FETCH    = 2,
  parameter logic [31:0] FETCH_STRIDE = 32'h2000,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned HOLD_PERIOD  = 0,
  parameter int unsigned HOLD_LEN     = 2,
  parameter string       INIT_FILE    = ""
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        pc_req_i,
  input  logic [ADDR_W-1:0]           pc_addr_i,
  output logic [NUM_FETCH*DATA_W-1:0] pc_data_o,
  output logic                        pc_valid_o,
  input  logic                        ex_req_i,
  input  logic                        ex_we_i,
  input  logic [ADDR_W-1:0]           ex_addr_i,
  input  logic [DATA_W-1:0]           ex_wdata_i,
  input  logic [DATA_W/8-1:0]         ex_be_i,
  output logic [DATA_W-1:0]           ex_rdata_o,
  output logic                        ex_rvalid_o,
  output logic                        ex_gnt_o,
  output logic                        hold_req_o,
  output logic                        err_o,
  output logic [31:0]                 wr_cnt_o
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam logic [2:0]  LAT_LAST = 3'(RD_LATENCY);

  // Word index is the byte address with the two low bits dropped; anything
  // at or beyond DEPTH words has no backing storage.
  function automatic logic oor_f(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] idx;
    idx = addr >> 2;
    return idx >= ADDR_W'(DEPTH);
  endfunction

  // ---------------------------------------------------------------------------
  // Storage. Left without reset so contents survive rstn.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Hold injection
  // ---------------------------------------------------------------------------
  logic hold_req;

  if (HOLD_PERIOD == 0) begin : g_no_hold
    assign hold_req = 1'b0;
  end else begin : g_hold
    localparam int unsigned HC_W = (HOLD_PERIOD > 1) ? $clog2(HOLD_PERIOD) : 1;

    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
      hold_cnt_d = hold_cnt_q + HC_W'(1);
      if (hold_cnt_q == HC_W'(HOLD_PERIOD - 1)) begin
        hold_cnt_d = '0;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        hold_cnt_q <= '0;
      end else begin
        hold_cnt_q <= hold_cnt_d;
      end
    end

    // The last HOLD_LEN counts of every period are the hold burst.
    assign hold_req = (hold_cnt_q >= HC_W'(HOLD_PERIOD - HOLD_LEN));
  end

  assign hold_req_o = hold_req;

  // ---------------------------------------------------------------------------
  // Fetch port: one registered read per lane, lane addresses wrap naturally
  // in the ADDR_W-bit adder.
  // ---------------------------------------------------------------------------
  logic pc_valid_q;

  for (genvar gi = 0; gi < NUM_FETCH; gi++) begin : g_lane
    localparam logic [ADDR_W-1:0] LANE_OFF = ADDR_W'(FETCH_STRIDE * gi);

    logic [ADDR_W-1:0] lane_addr;
    logic [IDX_W-1:0]  lane_idx;
    logic              lane_oor;
    logic [DATA_W-1:0] lane_data_q;

    assign lane_addr = pc_addr_i + LANE_OFF;
    assign lane_idx  = lane_addr[IDX_W+1:2];
    assign lane_oor  = oor_f(lane_addr);

    // Reads the array before any write at the same edge lands, so a fetch
    // colliding with a data write returns the old word.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        lane_data_q <= '0;
      end else if (pc_req_i) begin
        lane_data_q <= lane_oor ? '0 : mem_q[lane_idx];
      end
    end

    assign pc_data_o[gi*DATA_W +: DATA_W] = lane_data_q;
  end

  assign pc_valid_o = pc_valid_q;

  // ---------------------------------------------------------------------------
  // Data port
  // ---------------------------------------------------------------------------
  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        lat_q, lat_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rd_buf_q;
  logic              gnt_q;
  logic              err_q;
  logic [31:0]       wr_cnt_q;

  logic              ex_oor;
  logic [IDX_W-1:0]  ex_idx;
  logic              accept;
  logic              rd_accept;
  logic              wr_en;

  assign ex_oor    = oor_f(ex_addr_i);
  assign ex_idx    = ex_addr_i[IDX_W+1:2];
  assign accept    = (state_q == IDLE) & ex_req_i & ~hold_req;
  assign rd_accept = accept & ~ex_we_i;
  // rstn keeps a request that is high during reset from touching memory.
  assign wr_en     = rstn & accept & ex_we_i & ~ex_oor;

  // Write and read-sample share one process so the read at an accept edge
  // sees every write accepted at earlier edges.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (ex_be_i[b]) begin
          mem_q[ex_idx][b*8 +: 8] <= ex_wdata_i[b*8 +: 8];
        end
      end
    end
    if (rd_accept) begin
      rd_buf_q <= ex_oor ? '0 : mem_q[ex_idx];
    end
  end

  // lat_q counts edges spent in RD_WAIT; data is presented at the edge that
  // is RD_LATENCY edges after the accept edge.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (rd_accept) begin
          state_d = RD_WAIT;
          lat_d   = 3'd1;
        end
      end
      RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = rd_buf_q;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      gnt_q      <= 1'b0;
      err_q      <= 1'b0;
      wr_cnt_q   <= '0;
      pc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      gnt_q      <= accept;
      err_q      <= accept & ex_oor;
      pc_valid_q <= pc_req_i;
      if (wr_en) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
    end
  end

  assign ex_rdata_o  = rdata_q;
  assign ex_rvalid_o = rvalid_q;
  assign ex_gnt_o    = gnt_q;
  assign err_o       = err_q;
  assign wr_cnt_o    = wr_cnt_q;

endmodule

// File: tb/tb_nib_mem_responder.sv
module tb_nib_mem_responder;

  localparam int          DW     = 32;
  localparam int          AW     = 32;
  localparam int          DEP    = 64;
  localparam int          NF     = 2;
  localparam int          LAT    = 3;
  localparam int          HP     = 8;
  localparam int          HL     = 2;
  localparam logic [31:0] STRIDE = 32'h80;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              pc_req_i = 1'b0;
  logic [AW-1:0]     pc_addr_i = '0;
  logic [NF*DW-1:0]  pc_data_o;
  logic              pc_valid_o;
  logic              ex_req_i = 1'b0;
  logic              ex_we_i = 1'b0;
  logic [AW-1:0]     ex_addr_i = '0;
  logic [DW-1:0]     ex_wdata_i = '0;
  logic [DW/8-1:0]   ex_be_i = '0;
  logic [DW-1:0]     ex_rdata_o;
  logic              ex_rvalid_o;
  logic              ex_gnt_o;
  logic              hold_req_o;
  logic              err_o;
  logic [31:0]       wr_cnt_o;

  nib_mem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NUM_FETCH(NF),
    .FETCH_STRIDE(STRIDE), .RD_LATENCY(LAT), .HOLD_PERIOD(HP),
    .HOLD_LEN(HL), .INIT_FILE("")
  ) dut (
    .clk(clk), .rstn(rstn),
    .pc_req_i(pc_req_i), .pc_addr_i(pc_addr_i),
    .pc_data_o(pc_data_o), .pc_valid_o(pc_valid_o),
    .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_addr_i(ex_addr_i),
    .ex_wdata_i(ex_wdata_i), .ex_be_i(ex_be_i),
    .ex_rdata_o(ex_rdata_o), .ex_rvalid_o(ex_rvalid_o), .ex_gnt_o(ex_gnt_o),
    .hold_req_o(hold_req_o), .err_o(err_o), .wr_cnt_o(wr_cnt_o)
  );

  initial forever #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int elig; } req_t;
  typedef struct { logic [31:0] data; int due; } rd_t;
  typedef struct { logic [31:0] addr; int edge_n; } fetch_t;

  req_t        iq[$];     // data requests currently presented to the DUT
  rd_t         rq[$];     // accepted reads awaiting their data
  fetch_t      fq[$];     // fetches issued, keyed by the edge that samples them
  logic [31:0] mem_m [DEP];
  int unsigned wcnt_m = 0;
  int          cyc = 0;
  int          since_rst = 0;
  int          total = 0;
  int          bad = 0;
  bit          fetch_en = 1'b0;

  function automatic logic oor_m(input logic [31:0] a);
    return (a >> 2) >= 32'(DEP);
  endfunction

  function automatic logic [31:0] rd_m(input logic [31:0] a);
    return oor_m(a) ? 32'h0 : mem_m[a[7:2]];
  endfunction

  function automatic logic [31:0] merge_m(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // cycle bookkeeping: cyc = number of the most recent rising edge
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rstn) since_rst = 0;
    else since_rst++;
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    fetch_t      f;
    req_t        r;
    rd_t         d;
    bit          exp_fv;
    bit          rq_idle;
    bit          prev_hold;
    logic [63:0] exp_pc;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("reset_flags", {59'd0, pc_valid_o, ex_gnt_o, ex_rvalid_o, err_o, hold_req_o}, 64'd0);
        chk("reset_wr_cnt", {32'd0, wr_cnt_o}, 64'd0);
        chk("reset_rdata", {32'd0, ex_rdata_o}, 64'd0);
        chk("reset_pc_data", pc_data_o, 64'd0);
        rq.delete();
        fq.delete();
        wcnt_m = 0;
        prev_hold = 1'b0;
      end else begin
        rq_idle = (rq.size() == 0);
        chk("hold", {63'd0, hold_req_o}, {63'd0, ((since_rst % HP) >= (HP - HL))});

        while (fq.size() > 0 && fq[0].edge_n < cyc) begin
          chk("fetch_lost", 64'd0, 64'd1);
          void'(fq.pop_front());
        end
        exp_fv = (fq.size() > 0) && (fq[0].edge_n == cyc);
        chk("pc_valid", {63'd0, pc_valid_o}, {63'd0, exp_fv});
        if (exp_fv) begin
          f = fq.pop_front();
          exp_pc = {rd_m(f.addr + STRIDE), rd_m(f.addr)};
          chk("pc_data", pc_data_o, exp_pc);
        end

        if (ex_gnt_o) begin
          if (iq.size() == 0) begin
            chk("spurious_gnt", 64'd1, 64'd0);
          end else begin
            r = iq.pop_front();
            chk("gnt_during_hold", {63'd0, prev_hold}, 64'd0);
            chk("gnt_while_busy", {63'd0, rq_idle}, 64'd1);
            chk("err", {63'd0, err_o}, {63'd0, oor_m(r.addr)});
            if (r.we) begin
              if (!oor_m(r.addr)) begin
                mem_m[r.addr[7:2]] = merge_m(mem_m[r.addr[7:2]], r.wdata, r.be);
                wcnt_m++;
              end
              chk("wr_cnt", {32'd0, wr_cnt_o}, {32'd0, wcnt_m});
            end else begin
              rq.push_back('{rd_m(r.addr), cyc + LAT});
            end
          end
        end else begin
          chk("err_no_gnt", {63'd0, err_o}, 64'd0);
          if (iq.size() > 0 && iq[0].elig <= cyc && !prev_hold && rq_idle)
            chk("missed_accept", 64'd0, 64'd1);
        end

        if (ex_rvalid_o) begin
          if (rq.size() == 0) begin
            chk("spurious_rvalid", 64'd1, 64'd0);
          end else begin
            d = rq.pop_front();
            chk("rvalid_cycle", 64'(cyc), 64'(d.due));
            chk("rdata", {32'd0, ex_rdata_o}, {32'd0, d.data});
          end
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
          chk("rvalid_missing", 64'd0, 64'd1);
          void'(rq.pop_front());
        end
        prev_hold = hold_req_o;
      end
    end
  end

  // ---------------- fetch stimulus ----------------
  initial begin
    logic [31:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (fetch_en && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 9))
          0:       a = 32'hFFFF_FF80 + 32'($urandom_range(0, 31)) * 4;
          1:       a = 32'($urandom_range(32, DEP + 6)) * 4;
          default: a = 32'($urandom_range(0, DEP - 1)) * 4 + 32'($urandom_range(0, 3));
        endcase
        pc_req_i  = 1'b1;
        pc_addr_i = a;
        fq.push_back('{a, cyc + 1});
      end else begin
        pc_req_i  = 1'b0;
        pc_addr_i = $urandom();
      end
    end
  end

  // ---------------- data stimulus ----------------
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    int n;
    @(posedge clk);
    #1;
    ex_req_i   = 1'b1;
    ex_we_i    = we;
    ex_addr_i  = addr;
    ex_wdata_i = wd;
    ex_be_i    = be;
    iq.push_back('{we, addr, wd, be, cyc + 1});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ex_gnt_o && n < 200);
    ex_req_i = 1'b0;
    if (!ex_gnt_o) begin
      chk("gnt_timeout", 64'd0, 64'd1);
      iq.delete();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rq.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(rq.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    foreach (mem_m[i]) mem_m[i] = '0;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // fill every word so the model and the array agree from here on
    for (int i = 0; i < DEP; i++)
      do_txn(1'b1, 32'(i) * 4, (i == 16) ? 32'h1122_3344 : $urandom(), 4'hF);

    // byte-enable write over 11223344 -> 11BB33DD
    do_txn(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101);
    do_txn(1'b0, 32'h40, 32'h0, 4'h0);

    // range boundary: first word past the array, and the top of the space
    do_txn(1'b0, 32'(DEP) * 4, 32'h0, 4'h0);
    do_txn(1'b1, 32'(DEP) * 4, 32'hDEAD_BEEF, 4'hF);
    do_txn(1'b0, 32'(DEP - 1) * 4, 32'h0, 4'h0);
    do_txn(1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 4'hF);

    fetch_en = 1'b1;
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'($urandom_range(DEP, DEP + 7)) * 4 + 32'($urandom_range(0, 3));
        1:       a = $urandom() | 32'h8000_0000;
        default: a = 32'($urandom_range(0, DEP - 1)) * 4 + 32'($urandom_range(0, 3));
      endcase
      do_txn(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // back-to-back reads: second one is presented while the first is pending
    do_txn(1'b0, 32'h10, 32'h0, 4'h0);
    do_txn(1'b0, 32'h14, 32'h0, 4'h0);
    drain();

    fetch_en = 1'b0;
    repeat (3) @(posedge clk);

    // reset one cycle after a read is accepted: its data must never appear
    do_txn(1'b0, 32'h40, 32'h0, 4'h0);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (8) @(posedge clk);

    // contents survived reset
    do_txn(1'b0, 32'h40, 32'h0, 4'h0);
    drain();
    chk("idle_queue", 64'(iq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
